// File: rtl/collision_move_scheduler_if.sv
// Bundle of request/collision inputs and move/blocked outputs exchanged
// between the control decode side and the collision move scheduler.
interface collision_move_scheduler_if;
    logic [0:3] req;
    logic [0:3] collision;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       blocked;
    logic       busy;

    // Control/decode side: drives requests and collision flags.
    modport master (
        output req,
        output collision,
        input  move_valid,
        input  move_dir,
        input  blocked,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  collision,
        output move_valid,
        output move_dir,
        output blocked,
        output busy
    );
endinterface

// File: rtl/collision_move_scheduler.sv
// Collision move scheduler: on each step tick, picks one requested direction
// by round-robin, checks it against the held collision flag one cycle later,
// and emits either a move pulse or a blocked pulse followed by a lockout.
module collision_move_scheduler #(
    parameter int STEP_DIV     = 4,
    parameter int BLOCK_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    collision_move_scheduler_if.slave   bus
);
    localparam int CNT_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int LOCK_W = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_INIT =
        LOCK_W'((BLOCK_CYCLES > 0) ? (BLOCK_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  step_cnt_r;
    logic [1:0]        rr_ptr_r, rr_ptr_next_s;
    logic [1:0]        dir_r, dir_next_s;
    logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_next_s;
    logic              move_valid_r, move_valid_next_s;
    logic              blocked_r, blocked_next_s;
    logic [1:0]        move_dir_r, move_dir_next_s;
    logic              busy_r, busy_next_s;
    logic              tick_s;
    logic              req_any_s;
    logic [1:0]        winner_s;

    // First set request at or after ptr, scanning upward modulo 4.
    function automatic logic [1:0] rr_pick(input logic [0:3] req_v, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_v[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
                found = found;
            end
        end
        return win;
    endfunction

    assign tick_s    = (step_cnt_r == CNT_W'(STEP_DIV - 1));
    assign req_any_s = |bus.req;
    assign winner_s  = rr_pick(bus.req, rr_ptr_r);

    // Free-running step counter; keeps counting through DECIDE and LOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            step_cnt_r <= {CNT_W{1'b0}};
        end else begin
            step_cnt_r <= step_cnt_r + CNT_W'(1);
        end
    end

    // Next-state and registered-output decode for the scheduling FSM.
    always_comb begin
        state_next_s      = state_r;
        rr_ptr_next_s     = rr_ptr_r;
        dir_next_s        = dir_r;
        lock_cnt_next_s   = lock_cnt_r;
        move_valid_next_s = 1'b0;
        blocked_next_s    = 1'b0;
        move_dir_next_s   = move_dir_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && req_any_s) begin
                    dir_next_s    = winner_s;
                    rr_ptr_next_s = winner_s + 2'd1;
                    state_next_s  = ST_DECIDE;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_DECIDE: begin
                move_dir_next_s = dir_r;
                if (bus.collision[dir_r]) begin
                    blocked_next_s = 1'b1;
                    if (BLOCK_CYCLES == 0) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s    = ST_LOCK;
                        lock_cnt_next_s = LOCK_INIT;
                    end
                end else begin
                    move_valid_next_s = 1'b1;
                    state_next_s      = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (lock_cnt_r == {LOCK_W{1'b0}}) begin
                    state_next_s = ST_IDLE;
                end else begin
                    lock_cnt_next_s = lock_cnt_r - LOCK_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        busy_next_s = (state_next_s == ST_DECIDE) || (state_next_s == ST_LOCK);
    end

    // State, arbitration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= 2'd0;
            dir_r        <= 2'd0;
            lock_cnt_r   <= {LOCK_W{1'b0}};
            move_valid_r <= 1'b0;
            blocked_r    <= 1'b0;
            move_dir_r   <= 2'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            rr_ptr_r     <= rr_ptr_next_s;
            dir_r        <= dir_next_s;
            lock_cnt_r   <= lock_cnt_next_s;
            move_valid_r <= move_valid_next_s;
            blocked_r    <= blocked_next_s;
            move_dir_r   <= move_dir_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign bus.move_valid = move_valid_r;
    assign bus.blocked    = blocked_r;
    assign bus.move_dir   = move_dir_r;
    assign bus.busy       = busy_r;
endmodule
